// File: rtl/wbh_pkg.sv
// Shared types for the wb_host register-bus initiator.
package wbh_pkg;
    typedef enum logic [1:0] {
        WBH_IDLE   = 2'd0,
        WBH_ACCESS = 2'd1,
        WBH_RESP   = 2'd2
    } wbh_state_e;

    localparam int WBH_TMO_W = 8;
endpackage

// File: rtl/wbh_reg_master.sv
// Wishbone classic slave that turns each transfer into a single reg-bus access,
// with a bounded wait that answers with wbs_err_o if the responder never acks.
module wbh_reg_master
    import wbh_pkg::*;
#(
    parameter int ADDR_W  = 3,
    parameter int TIMEOUT = 16
) (
    input  logic              mclk,
    input  logic              p_reset_n,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [ADDR_W+1:0] wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    input  logic [3:0]        wbs_sel_i,
    output logic [31:0]       wbs_dat_o,
    output logic              wbs_ack_o,
    output logic              wbs_err_o,
    output logic              reg_cs,
    output logic              reg_wr,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [31:0]       reg_wdata,
    output logic [3:0]        reg_be,
    input  logic [31:0]       reg_rdata,
    input  logic              reg_ack,
    output logic              tmo_sticky
);

    localparam logic [WBH_TMO_W-1:0] TMO_LAST = WBH_TMO_W'(TIMEOUT - 1);

    wbh_state_e           state, state_nx;
    logic [WBH_TMO_W-1:0] cnt, cnt_nx;
    logic                 cs_nx, wr_nx, ack_nx, err_nx, sticky_nx;
    logic [ADDR_W-1:0]    addr_nx;
    logic [31:0]          wdata_nx, dat_nx;
    logic [3:0]           be_nx;

    // Byte-lane bits of the address carry no information on a word bus.
    logic unused_adr_lsb;
    assign unused_adr_lsb = ^wbs_adr_i[1:0];

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        cs_nx     = reg_cs;
        wr_nx     = reg_wr;
        addr_nx   = reg_addr;
        wdata_nx  = reg_wdata;
        be_nx     = reg_be;
        sticky_nx = tmo_sticky;
        ack_nx    = 1'b0;
        err_nx    = 1'b0;
        dat_nx    = '0;
        case (state)
            WBH_IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    wr_nx    = wbs_we_i;
                    addr_nx  = wbs_adr_i[ADDR_W+1:2];
                    wdata_nx = wbs_dat_i;
                    be_nx    = wbs_sel_i;
                    cs_nx    = 1'b1;
                    cnt_nx   = '0;
                    state_nx = WBH_ACCESS;
                end
            end
            WBH_ACCESS: begin
                // Ack wins over timeout, timeout wins over host abort.
                if (reg_ack) begin
                    cs_nx    = 1'b0;
                    dat_nx   = reg_wr ? 32'h0 : reg_rdata;
                    ack_nx   = 1'b1;
                    state_nx = WBH_RESP;
                end else if (cnt == TMO_LAST) begin
                    cs_nx     = 1'b0;
                    err_nx    = 1'b1;
                    sticky_nx = 1'b1;
                    state_nx  = WBH_RESP;
                end else if (!wbs_cyc_i) begin
                    cs_nx    = 1'b0;
                    state_nx = WBH_IDLE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            WBH_RESP: state_nx = WBH_IDLE;
            default: begin
                cs_nx    = 1'b0;
                state_nx = WBH_IDLE;
            end
        endcase
    end

    always_ff @(posedge mclk or negedge p_reset_n) begin
        if (!p_reset_n) begin
            state      <= WBH_IDLE;
            cnt        <= '0;
            reg_cs     <= 1'b0;
            reg_wr     <= 1'b0;
            reg_addr   <= '0;
            reg_wdata  <= '0;
            reg_be     <= '0;
            wbs_ack_o  <= 1'b0;
            wbs_err_o  <= 1'b0;
            wbs_dat_o  <= '0;
            tmo_sticky <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            reg_cs     <= cs_nx;
            reg_wr     <= wr_nx;
            reg_addr   <= addr_nx;
            reg_wdata  <= wdata_nx;
            reg_be     <= be_nx;
            wbs_ack_o  <= ack_nx;
            wbs_err_o  <= err_nx;
            wbs_dat_o  <= dat_nx;
            tmo_sticky <= sticky_nx;
        end
    end

endmodule

// File: tb/tb_wbh_reg_master.sv
// Bench for wbh_reg_master: directed scenarios plus random transfers scored
// against an outcome model built from the ack/timeout/abort precedence rules.
module tb_wbh_reg_master;
    localparam int ADDR_W  = 3;
    localparam int TIMEOUT = 16;
    localparam int NREG    = 1 << ADDR_W;

    logic              mclk = 1'b0;
    logic              p_reset_n = 1'b0;
    logic              wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
    logic [ADDR_W+1:0] wbs_adr_i = '0;
    logic [31:0]       wbs_dat_i = '0;
    logic [3:0]        wbs_sel_i = '0;
    logic [31:0]       wbs_dat_o;
    logic              wbs_ack_o, wbs_err_o;
    logic              reg_cs, reg_wr;
    logic [ADDR_W-1:0] reg_addr;
    logic [31:0]       reg_wdata;
    logic [3:0]        reg_be;
    logic [31:0]       reg_rdata = '0;
    logic              reg_ack = 1'b0;
    logic              tmo_sticky;

    int checks = 0, passes = 0;
    logic [31:0] rmem    [NREG];
    logic [31:0] ref_mem [NREG];
    bit resp_en = 0, stray = 0, exp_sticky = 0;
    int resp_dly = 1, cs_cnt = 0;

    always #5 mclk = ~mclk;

    wbh_reg_master #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .mclk(mclk), .p_reset_n(p_reset_n),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i),
        .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o),
        .reg_cs(reg_cs), .reg_wr(reg_wr), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_be(reg_be), .reg_rdata(reg_rdata),
        .reg_ack(reg_ack), .tmo_sticky(tmo_sticky)
    );

    // Responder: acks resp_dly cycles after it first sees the select.
    always @(negedge mclk) begin
        if (!reg_cs) cs_cnt = 0;
        else cs_cnt++;
        reg_ack = 1'b0;
        if (resp_en && reg_cs && cs_cnt == resp_dly + 1) begin
            reg_ack = 1'b1;
            if (reg_wr) begin
                for (int b = 0; b < 4; b++)
                    if (reg_be[b]) rmem[reg_addr][8*b +: 8] = reg_wdata[8*b +: 8];
            end else begin
                reg_rdata = rmem[reg_addr];
            end
        end
        if (stray) begin
            reg_ack   = 1'b1;
            reg_rdata = 32'hDEAD_BEEF;
        end
    end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // One host transfer; dly<0 means no responder, abort_k>0 drops cyc after that many select cycles.
    task automatic xfer(input logic we, input logic [ADDR_W+1:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int dly, input int abort_k,
                        output int cs_n, output int ack_n, output int err_n,
                        output logic [31:0] dat_seen, output bit fld_ok, output int ack_cyc);
        resp_en  = (dly >= 0);
        resp_dly = dly;
        cs_n = 0; ack_n = 0; err_n = 0; dat_seen = '0; fld_ok = 1; ack_cyc = -1;
        @(negedge mclk);
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = we;
        wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
        for (int c = 0; c < TIMEOUT + 8; c++) begin
            @(negedge mclk);
            if (reg_cs) begin
                cs_n++;
                if (reg_addr !== adr[ADDR_W+1:2] || reg_wr !== we ||
                    reg_wdata !== dat || reg_be !== sel) fld_ok = 0;
            end
            if (wbs_ack_o) begin ack_n++; dat_seen = wbs_dat_o; ack_cyc = c; end
            if (wbs_err_o) begin err_n++; dat_seen = wbs_dat_o; end
            if (wbs_ack_o || wbs_err_o) begin wbs_cyc_i = 0; wbs_stb_i = 0; end
            if (abort_k > 0 && reg_cs && cs_n == abort_k) begin wbs_cyc_i = 0; wbs_stb_i = 0; end
        end
        wbs_cyc_i = 0; wbs_stb_i = 0;
        resp_en = 0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({wbs_ack_o, wbs_err_o, wbs_dat_o, reg_cs, reg_wr, reg_addr, reg_wdata, reg_be, tmo_sticky} !== '0)
            $display("FAIL reset_hold: outputs not all zero (cs=%b ack=%b dat=%h)", reg_cs, wbs_ack_o, wbs_dat_o);
        else passes++;
        repeat (2) @(negedge mclk);
        p_reset_n = 1;
        repeat (2) @(negedge mclk);
        checks++;
        if ({wbs_ack_o, wbs_err_o, wbs_dat_o, reg_cs, tmo_sticky} !== '0)
            $display("FAIL reset_idle: outputs active with no request (cs=%b ack=%b)", reg_cs, wbs_ack_o);
        else passes++;
    endtask

    task automatic test_write();
        int cs_n, ack_n, err_n, ack_cyc; logic [31:0] d; bit ok;
        xfer(1'b1, 5'h08, 32'h1234_5678, 4'hF, 1, -1, cs_n, ack_n, err_n, d, ok, ack_cyc);
        ref_mem[2] = 32'h1234_5678;
        checks++; if (cs_n !== 2) $display("FAIL write_cs_len: got %0d want 2", cs_n); else passes++;
        checks++; if (ack_n !== 1) $display("FAIL write_ack: got %0d want 1", ack_n); else passes++;
        checks++; if (err_n !== 0) $display("FAIL write_err: got %0d want 0", err_n); else passes++;
        checks++; if (!ok) $display("FAIL write_fields: reg_addr/wr/wdata/be got %0d/%0d/%h/%h want 2/1/12345678/f", reg_addr, reg_wr, reg_wdata, reg_be); else passes++;
        checks++; if (ack_cyc !== 2) $display("FAIL write_latency: got %0d want 2", ack_cyc); else passes++;
        checks++; if (d !== 32'h0) $display("FAIL write_dat_o: got %h want 0", d); else passes++;
    endtask

    task automatic test_read();
        int cs_n, ack_n, err_n, ack_cyc; logic [31:0] d; bit ok;
        xfer(1'b0, 5'h14, 32'h0, 4'hF, 1, -1, cs_n, ack_n, err_n, d, ok, ack_cyc);
        checks++; if (d !== 32'h00A5_5A00) $display("FAIL read_data: got %h want 00a55a00", d); else passes++;
        checks++; if (cs_n !== 2) $display("FAIL read_cs_len: got %0d want 2", cs_n); else passes++;
        checks++; if (ack_n !== 1) $display("FAIL read_single_ack: got %0d want 1", ack_n); else passes++;
        checks++; if (!ok) $display("FAIL read_fields: reg_addr got %0d want 5", reg_addr); else passes++;
    endtask

    task automatic test_timeout();
        int cs_n, ack_n, err_n, ack_cyc, bad; logic [31:0] d; bit ok;
        xfer(1'b0, 5'h04, 32'h0, 4'hF, -1, -1, cs_n, ack_n, err_n, d, ok, ack_cyc);
        exp_sticky = 1;
        checks++; if (cs_n !== TIMEOUT) $display("FAIL tmo_cs_len: got %0d want %0d", cs_n, TIMEOUT); else passes++;
        checks++; if (err_n !== 1) $display("FAIL tmo_err: got %0d want 1", err_n); else passes++;
        checks++; if (ack_n !== 0) $display("FAIL tmo_ack: got %0d want 0", ack_n); else passes++;
        checks++; if (d !== 32'h0) $display("FAIL tmo_dat_o: got %h want 0", d); else passes++;
        checks++; if (tmo_sticky !== 1'b1) $display("FAIL tmo_sticky: got %b want 1", tmo_sticky); else passes++;
        // Stray ack with nothing outstanding.
        @(posedge mclk); #1 stray = 1;
        @(posedge mclk); #1 stray = 0;
        bad = 0;
        repeat (4) begin
            @(negedge mclk);
            if (wbs_ack_o || wbs_err_o || reg_cs || wbs_dat_o !== 32'h0) bad++;
        end
        checks++; if (bad !== 0) $display("FAIL stray_ack: got %0d active cycles want 0", bad); else passes++;
    endtask

    task automatic test_ack_at_timeout();
        int cs_n, ack_n, err_n, ack_cyc; logic [31:0] d, w; bit ok;
        w = $urandom;
        xfer(1'b1, 5'h10, w, 4'hF, TIMEOUT - 1, -1, cs_n, ack_n, err_n, d, ok, ack_cyc);
        ref_mem[4] = w;
        checks++; if (ack_n !== 1) $display("FAIL edge_ack: got %0d want 1", ack_n); else passes++;
        checks++; if (err_n !== 0) $display("FAIL edge_err: got %0d want 0", err_n); else passes++;
        checks++; if (tmo_sticky !== exp_sticky) $display("FAIL edge_sticky: got %b want %b", tmo_sticky, exp_sticky); else passes++;
    endtask

    task automatic test_abort();
        int cs_n, ack_n, err_n, ack_cyc; logic [31:0] d; bit ok;
        xfer(1'b1, 5'h0C, 32'hFFFF_FFFF, 4'hF, -1, 3, cs_n, ack_n, err_n, d, ok, ack_cyc);
        checks++; if (cs_n !== 3) $display("FAIL abort_cs_len: got %0d want 3", cs_n); else passes++;
        checks++; if (ack_n + err_n !== 0) $display("FAIL abort_resp: got %0d responses want 0", ack_n + err_n); else passes++;
        xfer(1'b0, 5'h10, 32'h0, 4'hF, 1, -1, cs_n, ack_n, err_n, d, ok, ack_cyc);
        checks++; if (ack_n !== 1) $display("FAIL abort_next_ack: got %0d want 1", ack_n); else passes++;
        checks++; if (d !== ref_mem[4]) $display("FAIL abort_next_data: got %h want %h", d, ref_mem[4]); else passes++;
    endtask

    task automatic test_reset_mid();
        int cs_n, ack_n, err_n, ack_cyc; logic [31:0] d; bit ok;
        @(negedge mclk);
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = 5'h14; wbs_sel_i = 4'hF;
        repeat (3) @(negedge mclk);
        #2 p_reset_n = 0;
        #1;
        checks++;
        if ({wbs_ack_o, wbs_err_o, wbs_dat_o, reg_cs, reg_wr, reg_addr, reg_wdata, reg_be, tmo_sticky} !== '0)
            $display("FAIL reset_mid: outputs not zero (cs=%b sticky=%b)", reg_cs, tmo_sticky);
        else passes++;
        exp_sticky = 0;
        wbs_cyc_i = 0; wbs_stb_i = 0;
        @(negedge mclk);
        p_reset_n = 1;
        xfer(1'b0, 5'h14, 32'h0, 4'hF, 1, -1, cs_n, ack_n, err_n, d, ok, ack_cyc);
        checks++; if (ack_n !== 1) $display("FAIL reset_mid_ack: got %0d want 1", ack_n); else passes++;
        checks++; if (d !== ref_mem[5]) $display("FAIL reset_mid_data: got %h want %h", d, ref_mem[5]); else passes++;
    endtask

    task automatic test_back_to_back();
        int acks; logic [31:0] d0, rd, exp;
        d0 = $urandom; acks = 0; rd = '0;
        resp_en = 1; resp_dly = 1;
        @(negedge mclk);
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1; wbs_adr_i = 5'h18; wbs_dat_i = d0; wbs_sel_i = 4'h3;
        for (int c = 0; c < 12; c++) begin
            @(negedge mclk);
            if (wbs_ack_o) begin
                acks++;
                if (acks == 1) begin wbs_we_i = 0; wbs_dat_i = '0; wbs_sel_i = 4'hF; end
                else begin rd = wbs_dat_o; wbs_cyc_i = 0; wbs_stb_i = 0; end
            end
        end
        wbs_cyc_i = 0; wbs_stb_i = 0; resp_en = 0;
        ref_mem[6] = merge(ref_mem[6], d0, 4'h3);
        exp = ref_mem[6];
        checks++; if (acks !== 2) $display("FAIL b2b_acks: got %0d want 2", acks); else passes++;
        checks++; if (rd !== exp) $display("FAIL b2b_data: got %h want %h", rd, exp); else passes++;
    endtask

    task automatic test_random();
        int cs_n, ack_n, err_n, ack_cyc, dly, ab, ack_edge, ab_edge, exp_cs;
        int exp_ack, exp_err;
        logic [31:0] d, w, exp_d; logic [3:0] s; logic [ADDR_W-1:0] a; logic we; bit ok;
        for (int i = 0; i < 40; i++) begin
            a   = ADDR_W'($urandom);
            we  = 1'($urandom);
            w   = $urandom;
            s   = 4'($urandom);
            dly = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 19));
            ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : -1;
            ack_edge = (dly >= 0) ? dly + 1 : 1000;
            ab_edge  = (ab > 0) ? ab : 1000;
            exp_ack = 0; exp_err = 0; exp_d = '0;
            if (ack_edge <= TIMEOUT && ack_edge <= ab_edge) begin
                exp_ack = 1; exp_cs = ack_edge;
                exp_d = we ? 32'h0 : ref_mem[a];
            end else if (ab_edge < TIMEOUT) begin
                exp_cs = ab_edge;
            end else begin
                exp_err = 1; exp_cs = TIMEOUT; exp_sticky = 1;
            end
            xfer(we, {a, 2'($urandom)}, w, s, dly, ab, cs_n, ack_n, err_n, d, ok, ack_cyc);
            if (exp_ack == 1 && we) ref_mem[a] = merge(ref_mem[a], w, s);
            checks++;
            if (cs_n !== exp_cs || ack_n !== exp_ack || err_n !== exp_err)
                $display("FAIL rand_outcome[%0d]: got cs=%0d ack=%0d err=%0d want cs=%0d ack=%0d err=%0d",
                         i, cs_n, ack_n, err_n, exp_cs, exp_ack, exp_err);
            else passes++;
            checks++; if (d !== exp_d) $display("FAIL rand_data[%0d]: got %h want %h", i, d, exp_d); else passes++;
            checks++; if (!ok) $display("FAIL rand_fields[%0d]: request fields changed or wrong", i); else passes++;
            checks++; if (tmo_sticky !== exp_sticky) $display("FAIL rand_sticky[%0d]: got %b want %b", i, tmo_sticky, exp_sticky); else passes++;
        end
    endtask

    initial begin
        for (int i = 0; i < NREG; i++) begin
            rmem[i]    = $urandom;
            ref_mem[i] = rmem[i];
        end
        rmem[5]    = 32'h00A5_5A00;
        ref_mem[5] = 32'h00A5_5A00;
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_ack_at_timeout();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
